// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams, transmitter strobe/busy and grant status shared by
// uart_tx_arbiter (slave side) and whatever drives it (master side).
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 uart_tx_start;
  logic [7:0]           uart_data;
  logic                 uart_tx_busy;
  logic                 grant_valid;
  logic [ID_W-1:0]      grant_id;
  logic                 frame_done;
  logic                 ack_timeout;

  modport slave (
    input  req_valid, req_data, req_last, uart_tx_busy,
    output req_ready, uart_tx_start, uart_data,
           grant_valid, grant_id, frame_done, ack_timeout
  );

  modport master (
    output req_valid, req_data, req_last, uart_tx_busy,
    input  req_ready, uart_tx_start, uart_data,
           grant_valid, grant_id, frame_done, ack_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte-stream
// requesters; a grant is held for a whole frame, capped at MAX_BURST bytes.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ID_W        = 2,
  parameter int unsigned MAX_BURST   = 16,
  parameter int unsigned ACK_TIMEOUT = 4
) (
  input logic               clk,
  input logic               reset,
  uart_tx_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_HOLD
  } state_e;

  state_e               state_q, state_d;
  logic                 grant_valid_q, grant_valid_d;
  logic [ID_W-1:0]      grant_id_q, grant_id_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [7:0]           burst_cnt_q, burst_cnt_d;
  logic [3:0]           to_cnt_q, to_cnt_d;
  logic                 last_q, last_d;
  logic [7:0]           data_q, data_d;
  logic                 start_q, start_d;
  logic [NUM_REQ-1:0]   ready_q, ready_d;
  logic                 frame_done_q, frame_done_d;
  logic                 ack_timeout_q, ack_timeout_d;

  logic                 arb_found;
  logic [ID_W-1:0]      arb_id;
  logic [2*NUM_REQ-1:0] arb_dbl;
  int unsigned          arb_pos;

  logic [ID_W-1:0]      load_id;
  logic                 load_valid;
  logic [7:0]           load_data;
  logic                 load_last;
  logic [NUM_REQ-1:0]   load_onehot;

  // Rotating the doubled valid vector puts the requester after rr_ptr at bit 0.
  always_comb begin
    arb_found = 1'b0;
    arb_id    = '0;
    arb_pos   = 0;
    arb_dbl   = {bus.req_valid, bus.req_valid} >> (32'(rr_ptr_q) + 1);
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (!arb_found && arb_dbl[j]) begin
        arb_found = 1'b1;
        arb_pos   = 32'(rr_ptr_q) + 1 + j;
        if (arb_pos >= NUM_REQ) begin
          arb_pos = arb_pos - NUM_REQ;
        end
        arb_id = ID_W'(arb_pos);
      end
    end
  end

  always_comb begin
    load_id     = (state_q == S_IDLE) ? arb_id : grant_id_q;
    load_valid  = 1'b0;
    load_data   = '0;
    load_last   = 1'b0;
    load_onehot = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == load_id) begin
        load_valid     = bus.req_valid[i];
        load_data      = bus.req_data[8*i +: 8];
        load_last      = bus.req_last[i];
        load_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_valid_d = grant_valid_q;
    grant_id_d    = grant_id_q;
    rr_ptr_d      = rr_ptr_q;
    burst_cnt_d   = burst_cnt_q;
    to_cnt_d      = to_cnt_q;
    last_d        = last_q;
    data_d        = data_q;
    start_d       = 1'b0;
    ready_d       = '0;
    frame_done_d  = 1'b0;
    ack_timeout_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!bus.uart_tx_busy && arb_found) begin
          grant_valid_d = 1'b1;
          grant_id_d    = arb_id;
          burst_cnt_d   = '0;
          state_d       = S_LOAD;
        end
      end
      S_LOAD: begin
        burst_cnt_d = (burst_cnt_q >= 8'(MAX_BURST)) ? 8'(MAX_BURST) : burst_cnt_q + 8'd1;
        to_cnt_d    = '0;
        state_d     = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (bus.uart_tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (to_cnt_q == 4'(ACK_TIMEOUT - 1)) begin
          ack_timeout_d = 1'b1;
          grant_valid_d = 1'b0;
          grant_id_d    = '0;
          rr_ptr_d      = grant_id_q;
          state_d       = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 4'd1;
        end
      end
      S_WAIT_DONE: begin
        if (!bus.uart_tx_busy) begin
          if (last_q || burst_cnt_q == 8'(MAX_BURST)) begin
            frame_done_d  = last_q;
            grant_valid_d = 1'b0;
            grant_id_d    = '0;
            rr_ptr_d      = grant_id_q;
            state_d       = S_IDLE;
          end else begin
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (load_valid && !bus.uart_tx_busy) begin
          state_d = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Strobe, byte, ready and last flag are registered on entry so they are
    // all presented together during the single LOAD cycle.
    if (state_d == S_LOAD && state_q != S_LOAD) begin
      start_d = 1'b1;
      data_d  = load_data;
      ready_d = load_onehot;
      last_d  = load_last;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      rr_ptr_q      <= ID_W'(NUM_REQ - 1);
      burst_cnt_q   <= '0;
      to_cnt_q      <= '0;
      last_q        <= 1'b0;
      data_q        <= '0;
      start_q       <= 1'b0;
      ready_q       <= '0;
      frame_done_q  <= 1'b0;
      ack_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      rr_ptr_q      <= rr_ptr_d;
      burst_cnt_q   <= burst_cnt_d;
      to_cnt_q      <= to_cnt_d;
      last_q        <= last_d;
      data_q        <= data_d;
      start_q       <= start_d;
      ready_q       <= ready_d;
      frame_done_q  <= frame_done_d;
      ack_timeout_q <= ack_timeout_d;
    end
  end

  assign bus.req_ready     = ready_q;
  assign bus.uart_tx_start = start_q;
  assign bus.uart_data     = data_q;
  assign bus.grant_valid   = grant_valid_q;
  assign bus.grant_id      = grant_id_q;
  assign bus.frame_done    = frame_done_q;
  assign bus.ack_timeout   = ack_timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: dut_a uses default limits, dut_b uses
// MAX_BURST=2; sel routes requester stimulus and observation to one of them.
module tb_uart_tx_arbiter;
  localparam int ACK = 4;
  localparam int K_S = 1;
  localparam int K_F = 2;
  localparam int K_T = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sel = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(4), .ID_W(2)) ifa ();
  uart_tx_arbiter_if #(.NUM_REQ(4), .ID_W(2)) ifb ();

  uart_tx_arbiter #(.NUM_REQ(4), .ID_W(2), .MAX_BURST(16), .ACK_TIMEOUT(ACK)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa.slave));
  uart_tx_arbiter #(.NUM_REQ(4), .ID_W(2), .MAX_BURST(2), .ACK_TIMEOUT(ACK)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb.slave));

  logic [3:0]  rv = '0;
  logic [31:0] rd = '0;
  logic [3:0]  rl = '0;
  logic [1:0]  busy = '0;
  int          bcnt [2];
  int          busy_len = 3;
  bit          stuck = 1'b0;

  assign ifa.req_valid    = sel ? 4'b0 : rv;
  assign ifb.req_valid    = sel ? rv : 4'b0;
  assign ifa.req_data     = rd;
  assign ifb.req_data     = rd;
  assign ifa.req_last     = rl;
  assign ifb.req_last     = rl;
  assign ifa.uart_tx_busy = busy[0];
  assign ifb.uart_tx_busy = busy[1];

  logic       obs_start, obs_fd, obs_to, obs_gv, obs_busy;
  logic [1:0] obs_gid;
  logic [7:0] obs_data;
  logic [3:0] obs_ready;
  assign obs_start = sel ? ifb.uart_tx_start : ifa.uart_tx_start;
  assign obs_fd    = sel ? ifb.frame_done    : ifa.frame_done;
  assign obs_to    = sel ? ifb.ack_timeout   : ifa.ack_timeout;
  assign obs_gv    = sel ? ifb.grant_valid   : ifa.grant_valid;
  assign obs_gid   = sel ? ifb.grant_id      : ifa.grant_id;
  assign obs_data  = sel ? ifb.uart_data     : ifa.uart_data;
  assign obs_ready = sel ? ifb.req_ready     : ifa.req_ready;
  assign obs_busy  = sel ? busy[1]           : busy[0];

  // Transmitter model: busy rises the cycle after the start strobe.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if ((k == 0 ? ifa.uart_tx_start : ifb.uart_tx_start) && !stuck) begin
        busy[k] <= 1'b1;
        bcnt[k] <= busy_len - 1;
      end else if (busy[k]) begin
        if (bcnt[k] == 0) busy[k] <= 1'b0;
        else bcnt[k] <= bcnt[k] - 1;
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  typedef struct { int kind; int id; int data; } ev_t;
  ev_t exp_q[$];

  task automatic ex(input int kind, input int id, input int data);
    ev_t e;
    e.kind = kind; e.id = id; e.data = data;
    exp_q.push_back(e);
  endtask

  logic [8:0] rq [4][$];

  task automatic push(input int i, input logic [7:0] d, input logic last);
    rq[i].push_back({last, d});
  endtask

  // Requesters: drop the accepted byte on ready, present the next one.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (obs_ready[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        if (rq[i].size() > 0) begin
          rv[i] = 1'b1;
          rd[8*i +: 8] = rq[i][0][7:0];
          rl[i] = rq[i][0][8];
        end else begin
          rv[i] = 1'b0;
          rd[8*i +: 8] = 8'h00;
          rl[i] = 1'b0;
        end
      end
    end
  end

  // Monitor: every start / frame_done / ack_timeout pulse consumes one expected event.
  initial begin
    int   fall_cyc, last_start, last_data, akind;
    bit   prev_busy;
    ev_t  e;
    fall_cyc = 0; last_start = 0; last_data = 0; prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_busy && !obs_busy) fall_cyc = cyc;
      prev_busy = obs_busy;
      if (!reset && (obs_start || obs_fd || obs_to)) begin
        akind = obs_start ? K_S : (obs_fd ? K_F : K_T);
        chk("event_single", 32'(obs_start) + 32'(obs_fd) + 32'(obs_to), 1);
        if (exp_q.size() == 0) begin
          chk("unexpected_event", akind, 0);
        end else begin
          e = exp_q.pop_front();
          chk("event_kind", akind, e.kind);
          if (akind == e.kind) begin
            if (akind == K_S) begin
              chk("start_id", obs_gid, e.id);
              chk("start_data", obs_data, e.data);
              chk("start_ready", obs_ready, 32'(1) << e.id);
              chk("start_gvalid", obs_gv, 1);
              last_start = cyc;
              last_data  = e.data;
            end else if (akind == K_F) begin
              chk("fd_latency", cyc - fall_cyc, 1);
              chk("fd_gvalid", obs_gv, 0);
              chk("fd_data_held", obs_data, last_data);
            end else begin
              chk("to_latency", cyc - last_start, ACK + 1);
              chk("to_gvalid", obs_gv, 0);
              chk("to_gid", obs_gid, 0);
            end
          end
        end
      end
    end
  end

  task automatic drain(input string name, input int budget);
    int c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk({name, "_drained"}, exp_q.size(), 0);
    exp_q.delete();
    repeat (30) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_start"}, obs_start, 0);
    chk({tag, "_ready"}, obs_ready, 0);
    chk({tag, "_gvalid"}, obs_gv, 0);
    chk({tag, "_gid"}, obs_gid, 0);
    chk({tag, "_fd"}, obs_fd, 0);
    chk({tag, "_to"}, obs_to, 0);
    chk({tag, "_data"}, obs_data, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int c;
    repeat (3) @(negedge clk);
    chk_zero("reset_state");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Round robin from reset pointer: 0,1,2,3 then 0,2
    ex(K_S, 0, 8'h10); ex(K_F, 0, 0); ex(K_S, 1, 8'h20); ex(K_F, 0, 0);
    ex(K_S, 2, 8'h30); ex(K_F, 0, 0); ex(K_S, 3, 8'h40); ex(K_F, 0, 0);
    push(0, 8'h10, 1); push(1, 8'h20, 1); push(2, 8'h30, 1); push(3, 8'h40, 1);
    drain("rr_all", 500);
    ex(K_S, 0, 8'h50); ex(K_F, 0, 0); ex(K_S, 2, 8'h60); ex(K_F, 0, 0);
    push(2, 8'h60, 1); push(0, 8'h50, 1);
    drain("rr_pair", 300);

    // Single byte, 20-cycle transmission
    busy_len = 20;
    ex(K_S, 0, 8'hA5); ex(K_F, 0, 0);
    push(0, 8'hA5, 1);
    drain("single", 300);
    chk("single_release", obs_gv, 0);
    busy_len = 3;

    // Frame lock: requester 1 keeps the grant until its last byte
    ex(K_S, 1, 8'h11); ex(K_S, 1, 8'h22); ex(K_S, 1, 8'h33); ex(K_F, 0, 0);
    ex(K_S, 2, 8'h44); ex(K_F, 0, 0);
    push(1, 8'h11, 0); push(1, 8'h22, 0); push(1, 8'h33, 1); push(2, 8'h44, 1);
    drain("frame_lock", 500);

    // Ack timeout with a transmitter that never goes busy
    stuck = 1'b1;
    ex(K_S, 3, 8'h55); ex(K_T, 0, 0); ex(K_S, 0, 8'h66); ex(K_T, 0, 0);
    push(3, 8'h55, 1); push(0, 8'h66, 1);
    drain("ack_timeout", 300);
    stuck = 1'b0;

    // Reset in the middle of a byte
    busy_len = 20;
    ex(K_S, 1, 8'h77);
    push(1, 8'h77, 1);
    c = 0;
    while ((exp_q.size() != 0 || !busy[0]) && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("mid_reset_reached", 32'(busy[0]), 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk_zero("mid_reset");
    busy_len = 3;
    ex(K_S, 0, 8'h88); ex(K_F, 0, 0); ex(K_S, 2, 8'h99); ex(K_F, 0, 0);
    push(2, 8'h99, 1); push(0, 8'h88, 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    c = 0;
    while (busy[0] && c < 100) begin
      chk("no_grant_while_busy", obs_gv, 0);
      @(negedge clk);
      c++;
    end
    drain("after_reset", 300);

    // Burst limit on dut_b (MAX_BURST=2)
    sel = 1'b1;
    repeat (2) @(negedge clk);
    ex(K_S, 3, 8'hA1); ex(K_S, 3, 8'hA2); ex(K_S, 0, 8'hB0); ex(K_F, 0, 0);
    ex(K_S, 3, 8'hA3); ex(K_S, 3, 8'hA4); ex(K_S, 3, 8'hA5);
    push(3, 8'hA1, 0); push(3, 8'hA2, 0); push(3, 8'hA3, 0); push(3, 8'hA4, 0); push(3, 8'hA5, 0);
    c = 0;
    while (!obs_gv && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("burst_first_grant", obs_gv, 1);
    push(0, 8'hB0, 1);
    drain("burst", 500);
    chk("burst_hold_gvalid", obs_gv, 1);
    chk("burst_hold_gid", obs_gid, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter among NUM_REQ byte-stream requesters using round-robin arbitration.
- Each requester offers bytes over a valid/ready handshake, with a last flag marking the end of a frame.
- The arbiter drives the transmitter's start strobe and data, then tracks its busy signal to sequence one byte at a time.
- Sits between the packet/command sources and the single UART transmitter instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of grant_id; must satisfy 2**ID_W >= NUM_REQ.
- MAX_BURST, 16, maximum bytes per grant before forced rotation (1..255).
- ACK_TIMEOUT, 4, cycles to wait for uart_tx_busy to rise after a start strobe (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester byte valid; held until the matching req_ready.
- req_data  in  8*NUM_REQ  byte for requester i at [8*i+7:8*i].
- req_last  in  NUM_REQ  byte is the final byte of a frame; qualified by req_valid.
- req_ready  out  NUM_REQ  one-cycle accept pulse; at most one bit high.
- uart_tx_start  out  1  one-cycle start strobe to the transmitter.
- uart_data  out  8  byte to the transmitter; held stable from the start strobe until the byte completes.
- uart_tx_busy  in  1  transmitter busy level.
- grant_valid  out  1  a requester currently owns the transmitter.
- grant_id  out  ID_W  index of the owning requester; 0 when grant_valid=0.
- frame_done  out  1  one-cycle pulse when a byte flagged last finishes.
- ack_timeout  out  1  one-cycle pulse when the transmitter fails to go busy within ACK_TIMEOUT.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, any state):
  - state=IDLE.
  - req_ready, uart_tx_start, grant_valid, grant_id, frame_done, ack_timeout = 0; uart_data=8'h00.
  - rr_ptr=NUM_REQ-1, so requester 0 has first priority.
  - burst_cnt=0, timeout counter=0.
- IDLE:
  - Arbitrate only if uart_tx_busy==0 and req_valid is nonzero.
  - Winner is the first set bit searching upward from rr_ptr+1, wrapping modulo NUM_REQ.
  - On the winning cycle: register grant_id=winner, grant_valid=1, burst_cnt=0; go to LOAD.
- LOAD (exactly one cycle):
  - uart_tx_start=1, uart_data=byte of grant_id, req_ready[grant_id]=1.
  - Latch the last flag; burst_cnt+=1; go to WAIT_ACK.
  - The start strobe occurs one cycle after the arbitration cycle.
- WAIT_ACK:
  - On uart_tx_busy==1, go to WAIT_DONE.
  - Otherwise count cycles. After ACK_TIMEOUT cycles without busy: pulse ack_timeout, drop grant (grant_valid=0, grant_id=0), rr_ptr=grant_id, go to IDLE.
  - The byte already accepted is lost and frame_done does not pulse.
- WAIT_DONE: on uart_tx_busy==0 the byte is complete.
  - If the latched last flag is set: pulse frame_done the same cycle, release grant, rr_ptr=grant_id, go to IDLE.
  - Else if burst_cnt==MAX_BURST: release grant, rr_ptr=grant_id, go to IDLE (no frame_done).
  - Else go to HOLD with the grant kept.
- HOLD:
  - The grant stays locked to the same requester.
  - If req_valid[grant_id]==1 and uart_tx_busy==0, go to LOAD.
  - Other requesters' valid bits are ignored.
  - The arbiter waits indefinitely; there is no hold timeout.
- burst_cnt is 8 bits and saturates at MAX_BURST; it clears on every new grant.
- Release followed by re-arbitration takes at least one IDLE cycle, so a released requester never wins back-to-back while others are valid.
- uart_data changes only in LOAD.
- req_ready never pulses outside LOAD.
- req_valid dropping without a ready is tolerated in IDLE/HOLD and ignored.
- Asserting reset mid-byte abandons the frame immediately. After reset, IDLE waits for uart_tx_busy==0 before the first grant.

Test Plan:
- Single byte: req_valid=4'b0001, data0=8'hA5, last0=1; UART busy rises 1 cycle after start and lasts 20 cycles -> one uart_tx_start with uart_data=A5, req_ready[0] pulses in the start cycle, frame_done pulses when busy falls, grant_valid returns to 0.
- Round robin: all four valid with last=1, one byte each -> grant order 0,1,2,3; then re-assert only 0 and 2 -> order 0,2.
- Frame lock: requester 1 sends 3 bytes 11,22,33 (last on 33) while requester 2 is valid throughout -> bytes 11,22,33 go out contiguously, then requester 2 is granted.
- Burst limit: MAX_BURST=2, requester 3 streams 5 bytes with no last while requester 0 is valid -> two bytes from 3, then grant to 0, then 3 resumes; frame_done does not pulse for 3.
- Ack timeout: uart_tx_busy tied 0 -> ack_timeout pulses exactly ACK_TIMEOUT+1 cycles after the start strobe, grant released, next requester granted.
- Reset mid-byte: assert reset in WAIT_DONE while busy=1 -> all outputs 0 immediately; after reset deasserts, no grant until busy falls, then requester 0 has priority.
